// File: rtl/vjtag_bridge_ctrl.sv
// ---------------------------------------------------------------------------
// vjtag_bridge_ctrl
//
// Host bridge between a 2-bit-IR virtual JTAG instance and the interpolation
// frame memory. Decodes the virtual IR, owns the DR shift register, drives
// tdo, and turns update-DR events into address loads, memory writes and read
// prefetches. Everything runs in the tck domain.
//
// Optional feature (compile-time macro):
//   VJTAG_BRIDGE_STATUS_EN  defined   -> ir_out_o = {err_ovf, err_und}
//                           undefined -> ir_out_o = ir_in_i (IR echo)
//
// Ports
//   tck_i        JTAG clock from vjtag, only clock of this block
//   rst_i        synchronous active-high reset
//   ir_in_i      virtual IR: 00 BYPASS, 01 ADDR, 10 WDATA, 11 RDATA
//   tdi_i        serial data in
//   cdr_i..uir_i vjtag virtual_state_* strobes
//   tdo_o        serial data out
//   ir_out_o     IR capture value
//   wr_valid_o   write request, held until accepted
//   wr_ready_i   memory accepts write when wr_valid_o & wr_ready_i
//   wr_addr_o    write address
//   wr_data_o    write data
//   rd_req_o     one-cycle read request pulse
//   rd_addr_o    read address, valid with rd_req_o
//   rd_valid_i   read data return strobe (latency >= 1)
//   rd_data_i    read data
//   err_ovf_o    sticky: write dropped while previous write pending
//   err_und_o    sticky: RDATA captured before prefetch returned
//
// Read FSM states
//   state   | meaning
//   RD_IDLE | no read outstanding, buffer empty; returns are ignored
//   RD_WAIT | prefetch issued, waiting for rd_valid_i
//   RD_FULL | rd_buf holds the word at the current address
// ---------------------------------------------------------------------------
module vjtag_bridge_ctrl #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic          tck_i,
  input  logic          rst_i,
  input  logic [1:0]    ir_in_i,
  input  logic          tdi_i,
  input  logic          cdr_i,
  input  logic          sdr_i,
  input  logic          e1dr_i,
  input  logic          pdr_i,
  input  logic          e2dr_i,
  input  logic          udr_i,
  input  logic          cir_i,
  input  logic          uir_i,
  output logic          tdo_o,
  output logic [1:0]    ir_out_o,
  output logic          wr_valid_o,
  input  logic          wr_ready_i,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          rd_req_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic          rd_valid_i,
  input  logic [DW-1:0] rd_data_i,
  output logic          err_ovf_o,
  output logic          err_und_o
);

  localparam logic [1:0] IR_BYPASS = 2'b00;
  localparam logic [1:0] IR_ADDR   = 2'b01;
  localparam logic [1:0] IR_WDATA  = 2'b10;
  localparam logic [1:0] IR_RDATA  = 2'b11;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_FULL = 2'd2;

  // Exit/pause strobes and IR-path strobes carry no DR action here.
  logic unused_strobes;
  assign unused_strobes = ^{e1dr_i, pdr_i, e2dr_i, cir_i, uir_i};

  logic [AW-1:0] sr_q, sr_d;
  logic          byp_q, byp_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] addr_inc;

  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic [1:0]    rd_state_q, rd_state_d;
  logic [DW-1:0] rd_buf_q, rd_buf_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          pf_pend_q, pf_pend_d;

  logic          err_ovf_q, err_ovf_d;
  logic          err_und_q, err_und_d;

  logic          rd_full;
  logic          wr_slot_free;

  assign addr_inc     = addr_q + AW'(1);
  assign rd_full      = (rd_state_q == RD_FULL);
  // A new write may load when nothing is pending or the pending one is
  // being accepted on this very edge (back-to-back writes).
  assign wr_slot_free = !wr_valid_q || wr_ready_i;

  always_comb begin
    sr_d       = sr_q;
    byp_d      = byp_q;
    addr_d     = addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_state_d = rd_state_q;
    rd_buf_d   = rd_buf_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    pf_pend_d  = 1'b0;
    err_ovf_d  = err_ovf_q;
    err_und_d  = err_und_q;

    if (wr_valid_q && wr_ready_i) begin
      wr_valid_d = 1'b0;
    end

    // Returns are only taken while waiting; in RD_IDLE they are stale
    // responses to a read issued before an ADDR reload.
    if ((rd_state_q == RD_WAIT) && rd_valid_i) begin
      rd_buf_d   = rd_data_i;
      rd_state_d = RD_FULL;
    end

    // Prefetch deferred by one cycle after an ADDR update.
    if (pf_pend_q && (rd_state_q == RD_IDLE)) begin
      rd_req_d   = 1'b1;
      rd_addr_d  = addr_q;
      rd_state_d = RD_WAIT;
    end

    if (cdr_i) begin
      case (ir_in_i)
        IR_BYPASS: byp_d = 1'b0;
        IR_ADDR:   sr_d  = addr_q;
        IR_WDATA:  sr_d  = '0;
        default: begin
          sr_d = '0;
          if (rd_full) begin
            sr_d[DW-1:0] = rd_buf_q;
          end else begin
            err_und_d = 1'b1;
          end
        end
      endcase
    end else if (sdr_i) begin
      case (ir_in_i)
        IR_BYPASS: byp_d = tdi_i;
        IR_ADDR:   sr_d  = {tdi_i, sr_q[AW-1:1]};
        default: begin
          // DW-bit scans: upper bits stay zero after capture, so a plain
          // right shift with tdi landing in bit DW-1 is enough.
          sr_d         = sr_q >> 1;
          sr_d[DW-1]   = tdi_i;
        end
      endcase
    end else if (udr_i) begin
      case (ir_in_i)
        IR_ADDR: begin
          // Address reload wins over a coincident read return: any buffered
          // or in-flight data belongs to the old address.
          addr_d     = sr_q;
          err_ovf_d  = 1'b0;
          err_und_d  = 1'b0;
          rd_state_d = RD_IDLE;
          pf_pend_d  = 1'b1;
        end
        IR_WDATA: begin
          if (wr_slot_free) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = sr_q[DW-1:0];
            addr_d     = addr_inc;
          end else begin
            err_ovf_d  = 1'b1;
          end
        end
        IR_RDATA: begin
          if (rd_full) begin
            addr_d     = addr_inc;
            rd_req_d   = 1'b1;
            rd_addr_d  = addr_inc;
            rd_state_d = RD_WAIT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      sr_q       <= '0;
      byp_q      <= 1'b0;
      addr_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_state_q <= RD_IDLE;
      rd_buf_q   <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      pf_pend_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_und_q  <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      byp_q      <= byp_d;
      addr_q     <= addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_state_q <= rd_state_d;
      rd_buf_q   <= rd_buf_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      pf_pend_q  <= pf_pend_d;
      err_ovf_q  <= err_ovf_d;
      err_und_q  <= err_und_d;
    end
  end

  assign tdo_o      = (ir_in_i == IR_BYPASS) ? byp_q : sr_q[0];
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign rd_req_o   = rd_req_q;
  assign rd_addr_o  = rd_addr_q;
  assign err_ovf_o  = err_ovf_q;
  assign err_und_o  = err_und_q;

`ifdef VJTAG_BRIDGE_STATUS_EN
  // Host sees error status on every IR scan.
  assign ir_out_o = {err_ovf_q, err_und_q};
`else
  assign ir_out_o = ir_in_i;
`endif

endmodule

// File: tb/tb_vjtag_bridge_ctrl.sv
module tb_vjtag_bridge_ctrl;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          tck = 1'b0;
  logic          rst, tdi, cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
  logic [1:0]    ir_in, ir_out;
  logic          tdo, wr_valid, wr_ready, rd_req, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          err_ovf, err_und;

  always #5 tck = ~tck;

  vjtag_bridge_ctrl #(.DW(DW), .AW(AW)) dut (
    .tck_i(tck), .rst_i(rst), .ir_in_i(ir_in), .tdi_i(tdi),
    .cdr_i(cdr), .sdr_i(sdr), .e1dr_i(e1dr), .pdr_i(pdr), .e2dr_i(e2dr),
    .udr_i(udr), .cir_i(cir), .uir_i(uir),
    .tdo_o(tdo), .ir_out_o(ir_out),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_valid_i(rd_valid), .rd_data_i(rd_data),
    .err_ovf_o(err_ovf), .err_und_o(err_und)
  );

  int n_pass = 0;
  int n_total = 0;

  // Transaction monitors (sampled mid-cycle).
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_rd_addr = '0;

  always @(negedge tck) begin
    if (rd_req) begin
      rd_cnt++;
      last_rd_addr = rd_addr;
    end
    if (wr_valid && wr_ready) wr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  // Full DR scan: capture, len shift bits (tdo sampled before each shift),
  // update, one idle cycle. rv/rvd drive rd_valid during update + idle.
  task automatic dr_scan(input logic [1:0] ir, input logic [15:0] din, input int len,
                         input logic rv, input logic [7:0] rvd, output logic [15:0] dout);
    dout = '0;
    ir_in = ir;
    cdr = 1'b1; tick(); cdr = 1'b0;
    for (int i = 0; i < len; i++) begin
      sdr = 1'b1;
      tdi = din[i];
      dout[i] = tdo;
      tick();
    end
    sdr = 1'b0; tdi = 1'b0;
    rd_valid = rv; rd_data = rvd;
    udr = 1'b1; tick(); udr = 1'b0;
    tick();
    rd_valid = 1'b0; rd_data = '0;
  endtask

  typedef struct {
    logic [1:0]  ir;
    logic [15:0] din;
    logic        rdy;
    logic [15:0] tdo;
    logic        wv;
    logic [15:0] wa;
    logic [7:0]  wd;
    int          wcnt;
    logic        ovf;
    logic        und;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [15:0] dout;
    logic [1:0]  exp_ir;
    logic [4:0]  bits;
    logic [4:0]  obs;
    logic [4:0]  exp_obs;
    int          wbase;
    int          rbase;

    //          ir     din       rdy   tdo       wv    wa        wd     wcnt ovf   und
    vt[0] = '{2'b01, 16'h0010, 1'b1, 16'h0011, 1'b0, 16'h0000, 8'h00, 0, 1'b0, 1'b0};
    vt[1] = '{2'b10, 16'h00A5, 1'b1, 16'h0000, 1'b0, 16'h0010, 8'hA5, 1, 1'b0, 1'b0};
    vt[2] = '{2'b10, 16'h003C, 1'b1, 16'h0000, 1'b0, 16'h0011, 8'h3C, 2, 1'b0, 1'b0};
    vt[3] = '{2'b10, 16'h0011, 1'b0, 16'h0000, 1'b1, 16'h0012, 8'h11, 2, 1'b0, 1'b0};
    vt[4] = '{2'b10, 16'h0022, 1'b0, 16'h0000, 1'b1, 16'h0012, 8'h11, 2, 1'b1, 1'b0};
    vt[5] = '{2'b01, 16'h0013, 1'b0, 16'h0013, 1'b1, 16'h0012, 8'h11, 2, 1'b0, 1'b0};
    vt[6] = '{2'b10, 16'h0033, 1'b1, 16'h0000, 1'b0, 16'h0013, 8'h33, 4, 1'b0, 1'b0};
    vt[7] = '{2'b01, 16'hFFFF, 1'b1, 16'h0014, 1'b0, 16'h0013, 8'h33, 4, 1'b0, 1'b0};
    vt[8] = '{2'b10, 16'h005A, 1'b1, 16'h0000, 1'b0, 16'hFFFF, 8'h5A, 5, 1'b0, 1'b0};
    vt[9] = '{2'b01, 16'h1234, 1'b1, 16'h0000, 1'b0, 16'hFFFF, 8'h5A, 5, 1'b0, 1'b0};

    rst = 1'b1; ir_in = 2'b00; tdi = 1'b0;
    cdr = 1'b0; sdr = 1'b0; e1dr = 1'b0; pdr = 1'b0; e2dr = 1'b0;
    udr = 1'b0; cir = 1'b0; uir = 1'b0;
    wr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (3) tick();

    check("rst tdo", tdo, 0);
    check("rst wr_valid", wr_valid, 0);
    check("rst rd_req", rd_req, 0);
    check("rst err_ovf", err_ovf, 0);
    check("rst err_und", err_und, 0);
    check("rst ir_out", ir_out, 0);
    rst = 1'b0;
    tick();

    // ADDR load and prefetch
    rbase = rd_cnt;
    dr_scan(2'b01, 16'h0010, 16, 1'b0, 8'h00, dout);
    check("addr capture", dout, 16'h0000);
    tick();
    check("prefetch count", rd_cnt - rbase, 1);
    check("prefetch addr", last_rd_addr, 16'h0010);
    rd_valid = 1'b1; rd_data = 8'h7E; tick(); rd_valid = 1'b0; rd_data = '0;
    repeat (2) tick();
    check("prefetch single pulse", rd_cnt - rbase, 1);

    // RDATA readout and next prefetch
    dr_scan(2'b11, 16'h0000, 8, 1'b0, 8'h00, dout);
    check("rdata tdo", dout, 16'h007E);
    check("rdata next req count", rd_cnt - rbase, 2);
    check("rdata next req addr", last_rd_addr, 16'h0011);
    check("rdata und", err_und, 0);
    rd_valid = 1'b1; rd_data = 8'h99; tick(); rd_valid = 1'b0; rd_data = '0;

    // Write / address table
    wbase = wr_cnt;
    for (int k = 0; k < 10; k++) begin
      wr_ready = vt[k].rdy;
      dr_scan(vt[k].ir, vt[k].din, (vt[k].ir == 2'b01) ? 16 : 8, 1'b0, 8'h00, dout);
      check($sformatf("v%0d tdo", k), dout, vt[k].tdo);
      check($sformatf("v%0d wr_valid", k), wr_valid, vt[k].wv);
      check($sformatf("v%0d wr_addr", k), wr_addr, vt[k].wa);
      check($sformatf("v%0d wr_data", k), wr_data, vt[k].wd);
      check($sformatf("v%0d writes", k), wr_cnt - wbase, vt[k].wcnt);
      check($sformatf("v%0d err_ovf", k), err_ovf, vt[k].ovf);
      check($sformatf("v%0d err_und", k), err_und, vt[k].und);
    end
    tick();
    check("table last prefetch", last_rd_addr, 16'h1234);

    // RDATA capture before return -> underflow
    rbase = rd_cnt;
    dr_scan(2'b11, 16'h0000, 8, 1'b0, 8'h00, dout);
    check("und tdo", dout, 16'h0000);
    check("und flag", err_und, 1);
    check("und no prefetch", rd_cnt - rbase, 0);
`ifdef VJTAG_BRIDGE_STATUS_EN
    exp_ir = 2'b01;
`else
    exp_ir = ir_in;
`endif
    check("ir_out und", ir_out, exp_ir);

    // ADDR update coincident with rd_valid; stale return in RD_IDLE
    dr_scan(2'b01, 16'h0100, 16, 1'b1, 8'h44, dout);
    check("addr unchanged by und", dout, 16'h1234);
    check("addr clears und", err_und, 0);
    rd_valid = 1'b1; rd_data = 8'h66; tick(); rd_valid = 1'b0; rd_data = '0;
    check("reload prefetch addr", last_rd_addr, 16'h0100);
    check("reload prefetch count", rd_cnt - rbase, 1);
    dr_scan(2'b11, 16'h0000, 8, 1'b0, 8'h00, dout);
    check("fresh data after reload", dout, 16'h0066);
    check("reload next req addr", last_rd_addr, 16'h0101);

    // Reset during pending write
    wr_ready = 1'b0;
    dr_scan(2'b10, 16'h0077, 8, 1'b0, 8'h00, dout);
    check("pending before rst", wr_valid, 1);
    check("pending addr", wr_addr, 16'h0101);
    rst = 1'b1; tick();
    check("rst wr_valid", wr_valid, 0);
    check("rst wr_addr", wr_addr, 0);
    rst = 1'b0; tick();
    dr_scan(2'b01, 16'hBEEF, 16, 1'b0, 8'h00, dout);
    check("addr after rst", dout, 16'h0000);

    // BYPASS: one-bit delay, capture clears
    bits = 5'b11101;
    obs = '0;
    ir_in = 2'b00;
    cdr = 1'b1; tick(); cdr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sdr = 1'b1; tdi = bits[i];
      obs[i] = tdo;
      tick();
    end
    sdr = 1'b0; tdi = 1'b0;
    exp_obs = {bits[3:0], 1'b0};
    check("bypass delay", obs, exp_obs);
    check("bypass last bit", tdo, bits[4]);
    udr = 1'b1; tick(); udr = 1'b0;
    cdr = 1'b1; tick(); cdr = 1'b0;
    check("bypass capture clears", tdo, 0);

    // Overflow status and IR capture value
    wr_ready = 1'b0;
    dr_scan(2'b10, 16'h0001, 8, 1'b0, 8'h00, dout);
    dr_scan(2'b10, 16'h0002, 8, 1'b0, 8'h00, dout);
    check("ovf flag", err_ovf, 1);
    check("ovf keeps first", wr_data, 8'h01);
    ir_in = 2'b00; #1;
`ifdef VJTAG_BRIDGE_STATUS_EN
    exp_ir = 2'b10;
`else
    exp_ir = 2'b00;
`endif
    check("ir_out ovf bypass", ir_out, exp_ir);
    ir_in = 2'b11; #1;
`ifdef VJTAG_BRIDGE_STATUS_EN
    exp_ir = 2'b10;
`else
    exp_ir = 2'b11;
`endif
    check("ir_out ovf rdata", ir_out, exp_ir);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
